// File: rtl/mac36_acc_pkg.sv
// Shared constants and helpers for the 36-element MAC / phase accumulator.
// Provides the vector length, default phase count, accumulator width rule
// and the rescale-and-saturate helper used by the output stage.
`ifndef MAC36_ACC_W
`define MAC36_ACC_W(dl) (2*(dl)+9)
`endif

package mac36_acc_pkg;

  localparam int VEC_LEN       = 36;
  localparam int NUM_PHASE_DEF = 8;

  // Accumulator width: 2*DATA_LEN product, +6 for the 36-way tree, +3 for 8 phases
  function automatic int acc_w(input int dl);
    return `MAC36_ACC_W(dl);
  endfunction

  // Arithmetic shift right (truncation toward -inf), then clamp to a dl-bit signed range
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                   input int frac,
                                                   input int dl);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = v >>> frac;
    hi = (64'sd1 <<< (dl - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dl - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/mac36_acc_if.sv
// Vector/result bundle between the weight-store controller and mac36_acc.
// master = controller side (drives vectors), slave = accumulator side.
// Packing: element i of w/x sits at bits [i*DATA_LEN +: DATA_LEN].
interface mac36_acc_if #(
  parameter int DATA_LEN = 16
);
  import mac36_acc_pkg::*;

  logic                        w_valid;
  logic [VEC_LEN*DATA_LEN-1:0] w;
  logic                        x_valid;
  logic [VEC_LEN*DATA_LEN-1:0] x;
  logic [2:0]                  phase;
  logic                        taken;
  logic                        busy;
  logic                        out_valid;
  logic [DATA_LEN-1:0]         out;

  modport master (
    output w_valid, w, x_valid, x, phase,
    input  taken, busy, out_valid, out
  );

  modport slave (
    input  w_valid, w, x_valid, x, phase,
    output taken, busy, out_valid, out
  );

endinterface

// File: rtl/mac36_tree.sv
// 36-way signed multiply and adder tree with valid/first/last sideband.
// Latency: 3 cycles (products, 9 partial sums of 4, total sum).
// No backpressure: a new vector may enter every cycle; stages never stall.
module mac36_tree
  import mac36_acc_pkg::*;
#(
  parameter int DATA_LEN = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               vld_i,
  input  logic                               first_i,
  input  logic                               last_i,
  input  logic [VEC_LEN*DATA_LEN-1:0]        w_i,
  input  logic [VEC_LEN*DATA_LEN-1:0]        x_i,
  output logic signed [2*DATA_LEN+6-1:0]     sum_o,
  output logic                               vld_o,
  output logic                               first_o,
  output logic                               last_o,
  output logic                               busy_o
);

  localparam int PW  = 2 * DATA_LEN;
  localparam int PSW = PW + 2;
  localparam int SW  = PW + 6;
  localparam int NPS = VEC_LEN / 4;

  logic signed [PW-1:0]  prod_d [VEC_LEN];
  logic signed [PW-1:0]  prod_q [VEC_LEN];
  logic signed [PSW-1:0] ps_d   [NPS];
  logic signed [PSW-1:0] ps_q   [NPS];
  logic signed [SW-1:0]  sum_d;
  logic signed [SW-1:0]  sum_q;
  logic vld1_q, vld2_q, vld3_q;
  logic first1_q, first2_q, first3_q;
  logic last1_q, last2_q, last3_q;

  for (genvar g = 0; g < VEC_LEN; g++) begin : g_mul
    logic signed [DATA_LEN-1:0] wg;
    logic signed [DATA_LEN-1:0] xg;
    assign wg        = w_i[g*DATA_LEN +: DATA_LEN];
    assign xg        = x_i[g*DATA_LEN +: DATA_LEN];
    assign prod_d[g] = PW'(wg) * PW'(xg);
  end

  for (genvar k = 0; k < NPS; k++) begin : g_ps
    assign ps_d[k] = PSW'(prod_q[4*k])   + PSW'(prod_q[4*k+1]) +
                     PSW'(prod_q[4*k+2]) + PSW'(prod_q[4*k+3]);
  end

  // Final reduction of the nine registered partial sums
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NPS; k++) begin
      sum_d = sum_d + SW'(ps_q[k]);
    end
  end

  // Stage flags: valid and first/last phase markers ride along with the data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      vld3_q   <= 1'b0;
      first1_q <= 1'b0;
      first2_q <= 1'b0;
      first3_q <= 1'b0;
      last1_q  <= 1'b0;
      last2_q  <= 1'b0;
      last3_q  <= 1'b0;
    end else begin
      vld1_q   <= vld_i;
      vld2_q   <= vld1_q;
      vld3_q   <= vld2_q;
      first1_q <= first_i;
      first2_q <= first1_q;
      first3_q <= first2_q;
      last1_q  <= last_i;
      last2_q  <= last1_q;
      last3_q  <= last2_q;
    end
  end

  // Datapath registers load only with a valid vector; flags guard their use
  always_ff @(posedge clk) begin
    if (vld_i)  prod_q <= prod_d;
    if (vld1_q) ps_q   <= ps_d;
    if (vld2_q) sum_q  <= sum_d;
  end

  assign sum_o   = sum_q;
  assign vld_o   = vld3_q;
  assign first_o = first3_q;
  assign last_o  = last3_q;
  assign busy_o  = vld1_q | vld2_q | vld3_q;

endmodule

// File: rtl/mac36_acc.sv
// Dot product of weight/activation vectors, accumulated over NUM_PHASE phases, rescaled and saturated.
// Latency: out_valid 4 cycles after the accept edge of the last phase; one accept per 2 cycles at most.
// Level-valid inputs with one accept per high period (rearm needs w_valid low); taken pulses on accept. Optional RELU_EN clamps negatives to 0.
module mac36_acc
  import mac36_acc_pkg::*;
#(
  parameter int DATA_LEN  = 16,
  parameter int FRAC      = 8,
  parameter int NUM_PHASE = NUM_PHASE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mac36_acc_if.slave bus
);

  localparam int ACC_W = acc_w(DATA_LEN);
  localparam int SUM_W = 2 * DATA_LEN + 6;

  logic armed_q;
  logic taken_q;
  logic accept;
  logic first_in;
  logic last_in;

  logic signed [SUM_W-1:0] t_sum;
  logic t_vld, t_first, t_last, t_busy;

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic                       vld4_q;
  logic                       last4_q;
  logic signed [DATA_LEN-1:0] out_d;
  logic signed [DATA_LEN-1:0] out_q;
  logic                       out_valid_q;

  assign accept   = bus.w_valid && bus.x_valid && armed_q;
  assign first_in = (bus.phase == 3'd0);
  assign last_in  = (bus.phase == 3'(NUM_PHASE - 1));

  // Arming: one accept per w_valid high period; rearm on any clock with w_valid low
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
      taken_q <= 1'b0;
    end else begin
      taken_q <= accept;
      if (accept) begin
        armed_q <= 1'b0;
      end else if (!bus.w_valid) begin
        armed_q <= 1'b1;
      end
    end
  end

  mac36_tree #(
    .DATA_LEN (DATA_LEN)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (accept),
    .first_i (first_in),
    .last_i  (last_in),
    .w_i     (bus.w),
    .x_i     (bus.x),
    .sum_o   (t_sum),
    .vld_o   (t_vld),
    .first_o (t_first),
    .last_o  (t_last),
    .busy_o  (t_busy)
  );

  // Phase 0 restarts the channel; later phases add in accept order
  always_comb begin
    acc_d = acc_q;
    if (t_first) begin
      acc_d = ACC_W'(t_sum);
    end else begin
      acc_d = acc_q + ACC_W'(t_sum);
    end
  end

  // Accumulator stage
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      vld4_q  <= 1'b0;
      last4_q <= 1'b0;
    end else begin
      vld4_q  <= t_vld;
      last4_q <= t_vld && t_last;
      if (t_vld) acc_q <= acc_d;
    end
  end

  // Rescale by FRAC (floor), saturate to DATA_LEN, optional rectification
  always_comb begin
    out_d = DATA_LEN'(sat_shift(64'(acc_q), FRAC, DATA_LEN));
`ifdef RELU_EN
    if (out_d[DATA_LEN-1]) out_d = '0;
`endif
  end

  // Output stage: publish only when the last phase of a channel lands
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= vld4_q && last4_q;
      if (vld4_q && last4_q) out_q <= out_d;
    end
  end

  assign bus.taken     = taken_q;
  assign bus.busy      = t_busy | vld4_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

endmodule
